hamming_rx_deframer: RTL

//  Serial-to-parallel front end for the Hamming(7,4) receive path.
//  - Recovers framed 7-bit codewords from a strobed serial bit stream.
//  - Frame = start(0) + 7 code bits + stop(1).
//  - Presents each codeword with its parity selection through a valid/ready handshake.
//  - Directly feeds hamming_error_correction:
//    - code_out -> code_in
//    - parity_type_out -> parity_type
//  - Counts framing errors and overruns for status registers.

---
 rtl/hamming_pkg.sv | 13 +
 rtl/hamming_sat_counter.sv | 23 ++
 rtl/hamming_rx_deframer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and FSM encoding for the Hamming(7,4) receive deframer.
package hamming_pkg;

  localparam int CODE_W     = 7;
  localparam int DATA_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/hamming_sat_counter.sv
// Saturating event counter; a clear takes priority over a same-cycle increment.
module hamming_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count register, holds at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hamming_rx_deframer.sv
// Serial deframer: start(0) + 7 code bits + stop(1) into a one-deep
// valid/ready holding register feeding the Hamming(7,4) corrector.
module hamming_rx_deframer
  import hamming_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             parity_sel,
  input  logic             code_ready,
  output logic [7:1]       code_out,
  output logic             code_valid,
  output logic             parity_type_out,
  output logic             frame_err,
  output logic             overrun,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] overrun_cnt
);

  state_t                state_r;
  state_t                next_state_s;
  logic [CODE_W-1:0]     shift_r;
  logic [DATA_CNT_W-1:0] cnt_r;
  logic                  par_r;
  logic                  load_s;
  logic                  ovr_s;
  logic                  ferr_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic, advances only on strobed bits
  always_comb begin
    next_state_s = state_r;
    if (bit_valid) begin
      case (state_r)
        IDLE: begin
          if (!bit_in) begin
            next_state_s = DATA;
          end else begin
            next_state_s = IDLE;
          end
        end
        DATA: begin
          if (cnt_r == DATA_CNT_W'(CODE_W - 1)) begin
            next_state_s = STOP;
          end else begin
            next_state_s = DATA;
          end
        end
        STOP:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // stop-bit outcome: load, overrun drop or framing error
  always_comb begin
    load_s = 1'b0;
    ovr_s  = 1'b0;
    ferr_s = 1'b0;
    if (bit_valid && (state_r == STOP)) begin
      if (bit_in) begin
        // the holding register counts as free if it drains this same cycle
        if (!code_valid || code_ready) begin
          load_s = 1'b1;
        end else begin
          ovr_s = 1'b1;
        end
      end else begin
        ferr_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
      ovr_s  = 1'b0;
      ferr_s = 1'b0;
    end
  end

  // shift register, bit counter and per-frame parity selection
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= {CODE_W{1'b0}};
      cnt_r   <= {DATA_CNT_W{1'b0}};
      par_r   <= 1'b0;
    end else if (bit_valid) begin
      case (state_r)
        IDLE: begin
          if (!bit_in) begin
            cnt_r <= {DATA_CNT_W{1'b0}};
            par_r <= parity_sel;
          end
        end
        DATA: begin
          if (MSB_FIRST) begin
            shift_r <= {shift_r[CODE_W-2:0], bit_in};
          end else begin
            shift_r <= {bit_in, shift_r[CODE_W-1:1]};
          end
          cnt_r <= cnt_r + DATA_CNT_W'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // output holding register and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      code_out        <= 7'b0000000;
      code_valid      <= 1'b0;
      parity_type_out <= 1'b0;
      frame_err       <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      frame_err <= ferr_s;
      overrun   <= ovr_s;
      if (load_s) begin
        code_out        <= shift_r;
        parity_type_out <= par_r;
        code_valid      <= 1'b1;
      end else if (code_valid && code_ready) begin
        code_valid <= 1'b0;
      end
    end
  end

  hamming_sat_counter #(.W(CNT_W)) u_frame_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (frame_err),
    .count (frame_err_cnt)
  );

  hamming_sat_counter #(.W(CNT_W)) u_overrun_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (overrun),
    .count (overrun_cnt)
  );

endmodule
